// File: rtl/seven_seg_decoder_pkg.sv
// Shared seven-segment definitions: active-low glyphs (bit 0 = a .. bit 6 = g) and decoder FSM states.
// The glyph table is common with the display encoder, so both sides agree on every pattern.
package seg_pkg;

  localparam logic [6:0] SEG_OFF = 7'b1111111;

  localparam logic [6:0] GLYPH_0 = 7'b1000000;
  localparam logic [6:0] GLYPH_1 = 7'b1111001;
  localparam logic [6:0] GLYPH_2 = 7'b0100100;
  localparam logic [6:0] GLYPH_3 = 7'b0110000;
  localparam logic [6:0] GLYPH_4 = 7'b0011001;
  localparam logic [6:0] GLYPH_5 = 7'b0010010;
  localparam logic [6:0] GLYPH_6 = 7'b0000010;
  localparam logic [6:0] GLYPH_7 = 7'b1111000;
  localparam logic [6:0] GLYPH_8 = 7'b0000000;
  localparam logic [6:0] GLYPH_9 = 7'b0011000;
  localparam logic [6:0] GLYPH_A = 7'b0001000;
  localparam logic [6:0] GLYPH_B = 7'b0000011;
  localparam logic [6:0] GLYPH_C = 7'b1000110;
  localparam logic [6:0] GLYPH_D = 7'b0100001;
  localparam logic [6:0] GLYPH_E = 7'b0000110;
  localparam logic [6:0] GLYPH_F = 7'b0001110;

  // Index n holds the glyph for nibble n.
  localparam logic [15:0][6:0] GLYPHS = {
    GLYPH_F, GLYPH_E, GLYPH_D, GLYPH_C, GLYPH_B, GLYPH_A, GLYPH_9, GLYPH_8,
    GLYPH_7, GLYPH_6, GLYPH_5, GLYPH_4, GLYPH_3, GLYPH_2, GLYPH_1, GLYPH_0
  };

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    LOCKED = 2'd2
  } state_t;

endpackage

// File: rtl/seven_seg_decoder_if.sv
// Loopback bus between the display pins and the decoder: sampled seg/anode lines in, decoded status out.
// No flow control; the status outputs are level signals plus the one-cycle update strobe.
interface seven_seg_decoder_if;
  logic [6:0] seg;
  logic [1:0] anode;
  logic [3:0] digit0;
  logic [3:0] digit1;
  logic [1:0] valid;
  logic [1:0] err;
  logic       update;
  logic       conflict;

  modport master (
    output seg, anode,
    input  digit0, digit1, valid, err, update, conflict
  );

  modport slave (
    input  seg, anode,
    output digit0, digit1, valid, err, update, conflict
  );
endinterface

// File: rtl/seven_seg_decoder_pattern_decode.sv
// Combinational inverse glyph lookup: 7-bit active-low pattern to hex nibble plus hit flag.
// Zero latency; any pattern outside the glyph table (all-off included) reports a miss.
module seg_pattern_decode
  import seg_pkg::*;
(
  input  logic [6:0] i_seg,
  output logic [3:0] o_nibble,
  output logic       o_hit
);

  always_comb begin
    o_nibble = 4'h0;
    o_hit    = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (i_seg == GLYPHS[i]) begin
        o_nibble = 4'(i);
        o_hit    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/seven_seg_decoder.sv
// Two-digit seven-segment receive monitor: write lands 2+STABLE_CYCLES cycles after the pins settle; no backpressure.
// Optional SEG_DECODE_TIMEOUT_EN drops a digit's valid after TIMEOUT_CYCLES without a fresh write.
module seven_seg_decoder
  import seg_pkg::*;
#(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic               clk,
  input  logic               reset_n,
  seven_seg_decoder_if.slave bus
);

  localparam int              CW      = $clog2(STABLE_CYCLES + 1);
  localparam logic [CW-1:0]   CNT_MAX = '1;
  // The first matching sample is count zero, so the lock fires once STABLE_CYCLES-1 repeats follow it.
  localparam logic [CW-1:0]   LOCK_AT = CW'(STABLE_CYCLES - 1);

  logic [6:0]    r_seg_m, r_seg_s, r_seg_l;
  logic [1:0]    r_an_m, r_an_s, r_an_l;
  state_t        r_state, w_state_nx;
  logic [CW-1:0] r_cnt, w_cnt_nx, w_cnt_inc;
  logic [CW-1:0] r_cf_cnt, w_cf_nx, w_cf_inc;
  logic          w_single, w_changed, w_sel, w_enter, w_hit, w_cf_set;
  logic [3:0]    w_nib;
  logic [1:0]    w_wr, w_miss, w_to_exp;
  logic [3:0]    r_digit0, r_digit1;
  logic [1:0]    r_valid, r_err;
  logic          r_update, r_conflict;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_seg_m <= SEG_OFF;
      r_seg_s <= SEG_OFF;
      r_seg_l <= SEG_OFF;
      r_an_m  <= 2'b11;
      r_an_s  <= 2'b11;
      r_an_l  <= 2'b11;
    end else begin
      r_seg_m <= bus.seg;
      r_seg_s <= r_seg_m;
      r_seg_l <= r_seg_s;
      r_an_m  <= bus.anode;
      r_an_s  <= r_an_m;
      r_an_l  <= r_an_s;
    end
  end

  assign w_single  = (r_an_s == 2'b10) || (r_an_s == 2'b01);
  assign w_sel     = (r_an_s == 2'b01);
  assign w_changed = (r_seg_s != r_seg_l) || (r_an_s != r_an_l);
  assign w_cnt_inc = (r_cnt == CNT_MAX) ? r_cnt : r_cnt + 1'b1;

  seg_pattern_decode u_decode (
    .i_seg   (r_seg_s),
    .o_nibble(w_nib),
    .o_hit   (w_hit)
  );

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_enter    = 1'b0;
    case (r_state)
      IDLE: begin
        w_cnt_nx = '0;
        if (w_single) begin
          if (LOCK_AT == '0) begin
            w_state_nx = LOCKED;
            w_enter    = 1'b1;
          end else begin
            w_state_nx = SETTLE;
          end
        end
      end
      SETTLE: begin
        if (!w_single) begin
          w_state_nx = IDLE;
          w_cnt_nx   = '0;
        end else if (w_changed) begin
          w_cnt_nx = '0;
        end else if (w_cnt_inc >= LOCK_AT) begin
          w_state_nx = LOCKED;
          w_cnt_nx   = '0;
          w_enter    = 1'b1;
        end else begin
          w_cnt_nx = w_cnt_inc;
        end
      end
      LOCKED: begin
        if (w_changed) begin
          w_cnt_nx = '0;
          if (!w_single) begin
            w_state_nx = IDLE;
          end else if (LOCK_AT == '0) begin
            w_enter = 1'b1;
          end else begin
            w_state_nx = SETTLE;
          end
        end
      end
      default: begin
        w_state_nx = IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // Conflict tracking runs beside the FSM, which never leaves IDLE while both anodes are low.
  assign w_cf_inc = (r_cf_cnt == CNT_MAX) ? r_cf_cnt : r_cf_cnt + 1'b1;
  assign w_cf_nx  = (r_an_s != 2'b00) ? '0 : (r_an_l == 2'b00) ? w_cf_inc : '0;
  assign w_cf_set = (r_an_s == 2'b00) && (w_cf_nx >= LOCK_AT);

  assign w_wr   = {w_enter && w_hit && w_sel, w_enter && w_hit && !w_sel};
  assign w_miss = {w_enter && !w_hit && w_sel, w_enter && !w_hit && !w_sel};

`ifdef SEG_DECODE_TIMEOUT_EN
  localparam int            TW      = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TO_LAST = TW'(TIMEOUT_CYCLES - 1);
  logic [1:0][TW-1:0] r_to_cnt;

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_to_cnt <= '0;
    end else begin
      for (int d = 0; d < 2; d++) begin
        if (w_wr[d] || w_to_exp[d]) r_to_cnt[d] <= '0;
        else if (r_valid[d])        r_to_cnt[d] <= r_to_cnt[d] + 1'b1;
      end
    end
  end

  always_comb begin
    w_to_exp = 2'b00;
    for (int d = 0; d < 2; d++) w_to_exp[d] = r_valid[d] && (r_to_cnt[d] == TO_LAST);
  end
`else
  // Timeout compiled out: valid bits hold until reset.
  assign w_to_exp = (TIMEOUT_CYCLES < 0) ? 2'b11 : 2'b00;
`endif

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_cf_cnt   <= '0;
      r_digit0   <= 4'h0;
      r_digit1   <= 4'h0;
      r_valid    <= 2'b00;
      r_err      <= 2'b00;
      r_update   <= 1'b0;
      r_conflict <= 1'b0;
    end else begin
      r_state    <= w_state_nx;
      r_cnt      <= w_cnt_nx;
      r_cf_cnt   <= w_cf_nx;
      if (w_wr[0]) r_digit0 <= w_nib;
      if (w_wr[1]) r_digit1 <= w_nib;
      r_valid    <= (r_valid & ~w_to_exp) | w_wr;
      r_err      <= r_err | w_miss;
      r_update   <= |w_wr;
      r_conflict <= r_conflict | w_cf_set;
    end
  end

  assign bus.digit0   = r_digit0;
  assign bus.digit1   = r_digit1;
  assign bus.valid    = r_valid;
  assign bus.err      = r_err;
  assign bus.update   = r_update;
  assign bus.conflict = r_conflict;

endmodule

// File: tb/tb_seven_seg_decoder.sv
// Directed bench for seven_seg_decoder: expected writes are queued at stimulus time and checked on each update pulse.
// Builds with or without SEG_DECODE_TIMEOUT_EN; the valid model follows the same macro.
module tb_seven_seg_decoder;
  import seg_pkg::*;

  localparam int S  = 4;
  localparam int TO = 32;

  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  seven_seg_decoder_if bus ();

  seven_seg_decoder #(
    .STABLE_CYCLES (S),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .bus    (bus)
  );

  typedef struct {
    int         d;
    logic [3:0] v;
    int         at;
  } exp_t;

  exp_t sb[$];
  int   cyc   = 0;
  int   total = 0;
  int   bad   = 0;
  int   wr_at[2] = '{-1, -1};
  int   u;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic [3:0] dig(input int d);
    return (d != 0) ? bus.digit1 : bus.digit0;
  endfunction

  // Reference for valid: set by an expected write, cleared TO cycles later only when timeout is built in.
  function automatic logic exp_valid(input int d);
    if (wr_at[d] < 0) return 1'b0;
`ifdef SEG_DECODE_TIMEOUT_EN
    return (cyc - wr_at[d]) < TO;
`else
    return 1'b1;
`endif
  endfunction

  function automatic logic [1:0] exp_valid2();
    return {exp_valid(1), exp_valid(0)};
  endfunction

  task automatic hold(input logic [1:0] a, input logic [6:0] s, input int n);
    bus.anode = a;
    bus.seg   = s;
    repeat (n) @(negedge clk);
  endtask

  task automatic expect_wr(input int d, input logic [3:0] v);
    sb.push_back('{d: d, v: v, at: cyc + 2 + S});
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digit0"}, bus.digit0, 4'h0);
    chk({tag, "_digit1"}, bus.digit1, 4'h0);
    chk({tag, "_valid"}, bus.valid, 2'b00);
    chk({tag, "_err"}, bus.err, 2'b00);
    chk({tag, "_update"}, bus.update, 1'b0);
    chk({tag, "_conflict"}, bus.conflict, 1'b0);
  endtask

  always @(negedge clk) begin
    if (reset_n === 1'b1 && bus.update === 1'b1) begin
      if (sb.size() == 0) begin
        total++;
        bad++;
        $display("FAIL spurious_update: got update=1 expected no write (cycle %0d)", cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("update_cycle", cyc, e.at);
        chk("update_digit", dig(e.d), e.v);
        chk("update_valid", bus.valid[e.d], 1'b1);
        wr_at[e.d] = e.at;
      end
    end
  end

  initial begin
    reset_n   = 1'b0;
    bus.anode = 2'b11;
    bus.seg   = SEG_OFF;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset_n = 1'b1;
    hold(2'b11, SEG_OFF, 2);

    // Digit 0 shows '2'; single update at 2+S cycles.
    expect_wr(0, 4'h2);
    hold(2'b10, 7'b0100100, 10);
    chk("t1_digit0", bus.digit0, 4'h2);
    chk("t1_valid", bus.valid, exp_valid2());
    hold(2'b11, SEG_OFF, 3);

    // Digit 1 'C' then straight to digit 0 '9' with no idle gap.
    expect_wr(1, 4'hC);
    hold(2'b01, 7'b1000110, 8);
    expect_wr(0, 4'h9);
    hold(2'b10, 7'b0011000, 8);
    chk("t2_digit1", bus.digit1, 4'hC);
    chk("t2_digit0", bus.digit0, 4'h9);
    chk("t2_valid", bus.valid, exp_valid2());

    // Pattern changes every 3 cycles never reaches a 4-sample window.
    for (int i = 0; i < 6; i++) hold(2'b10, (i % 2 != 0) ? 7'b1111001 : 7'b0000000, 3);
    hold(2'b11, SEG_OFF, 4);
    chk("glitch_digit0", bus.digit0, 4'h9);
    chk("glitch_valid", bus.valid, exp_valid2());

    // Unknown glyph on digit 1, then all-off on digit 0.
    hold(2'b01, 7'b1010101, 10);
    chk("badglyph_err", bus.err, 2'b10);
    chk("badglyph_digit1", bus.digit1, 4'hC);
    chk("badglyph_valid", bus.valid, exp_valid2());
    hold(2'b11, SEG_OFF, 2);
    hold(2'b10, SEG_OFF, 10);
    chk("alloff_err", bus.err, 2'b11);
    chk("alloff_digit0", bus.digit0, 4'h9);

    // Conflict one sample short of the window, then a full window.
    hold(2'b00, 7'b0000000, S - 1);
    hold(2'b11, SEG_OFF, 4);
    chk("short_conflict", bus.conflict, 1'b0);
    hold(2'b00, 7'b0000000, 8);
    hold(2'b11, SEG_OFF, 3);
    chk("conflict_set", bus.conflict, 1'b1);
    chk("conflict_digit0", bus.digit0, 4'h9);
    chk("conflict_digit1", bus.digit1, 4'hC);

    // One-cycle reset restores everything.
    reset_n  = 1'b0;
    wr_at[0] = -1;
    wr_at[1] = -1;
    @(negedge clk);
    reset_n = 1'b1;
    chk_reset_vals("rst_pulse");

    // Reset mid-SETTLE must not leave a partial write.
    bus.anode = 2'b10;
    bus.seg   = GLYPH_F;
    repeat (4) @(negedge clk);
    reset_n   = 1'b0;
    bus.anode = 2'b11;
    bus.seg   = SEG_OFF;
    @(negedge clk);
    reset_n = 1'b1;
    hold(2'b11, SEG_OFF, 8);
    chk("midsettle_valid", bus.valid, 2'b00);
    chk("midsettle_digit0", bus.digit0, 4'h0);

    // Accept '7' on digit 0, then go idle past the timeout window.
    u = cyc + 2 + S;
    expect_wr(0, 4'h7);
    hold(2'b10, 7'b1111000, 8);
    bus.anode = 2'b11;
    bus.seg   = SEG_OFF;
    while (cyc < u + TO - 1) @(negedge clk);
    chk("to_before_valid0", bus.valid[0], exp_valid(0));
    @(negedge clk);
    chk("to_edge_valid0", bus.valid[0], exp_valid(0));
    while (cyc < u + 40) @(negedge clk);
    chk("to_late_valid0", bus.valid[0], exp_valid(0));
    chk("to_digit0", bus.digit0, 4'h7);

    repeat (3) @(negedge clk);
    chk("pending_writes", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
